div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the execute stage (DIV/DIVU).
- Raises stall_req toward the hazard unit, which holds F/D/E while the division runs.
- Delivers HI (remainder) and LO (quotient) with a one-cycle-visible done; releases only on ack from the pipeline.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states and a two's-complement negate helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} div_state_t;

  // Callers narrow the result back to their own operand width.
  function automatic logic [DIV_MAX_W-1:0] negWide(input logic [DIV_MAX_W-1:0] v);
    return ~v + DIV_MAX_W'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividendBit,
  output logic [WIDTH:0]   remOut,
  output logic             qBit
);

  logic [WIDTH+1:0] diff;

  // NOTE: every output is assigned on every path through this block, so no latch can be inferred.
  always_comb begin
    diff   = {remIn, dividendBit} - {2'b00, divisor};
    qBit   = ~diff[WIDTH+1];
    remOut = qBit ? diff[WIDTH:0] : {remIn[WIDTH-1:0], dividendBit};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with a stall handshake toward the hazard unit.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle instead of the full iteration run.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ack,
  input  logic             flush,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
    return WIDTH'(negWide(DIV_MAX_W'(v)));
  endfunction

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] aOrig;
  logic             signQ;
  logic             signR;
  logic             bZero;
  logic             aNeg;
  logic             bNeg;
  logic             accept;
  logic [WIDTH:0]   stepRem;
  logic             stepQ;

  assign aNeg   = signed_div & a[WIDTH-1];
  assign bNeg   = signed_div & b[WIDTH-1];
  assign accept = (state == IDLE) && start && !flush;

  // Combinational so the hazard unit freezes E in the very cycle the divide is accepted.
  assign stall_req = accept || (!flush && (state == BUSY || state == FIX));

  // quo doubles as the dividend shifter: its MSB feeds the step, quotient bits enter at the LSB.
  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn      (rem),
    .divisor    (divisor),
    .dividendBit(quo[WIDTH-1]),
    .remOut     (stepRem),
    .qBit       (stepQ)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well; they are few and this keeps simulation X-free.
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      aOrig   <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      bZero   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            aOrig   <= a;
            quo     <= aNeg ? negW(a) : a;
            divisor <= bNeg ? negW(b) : b;
            signQ   <= aNeg ^ bNeg;
            signR   <= aNeg;
            bZero   <= (b == '0);
            rem     <= '0;
            cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
              hi    <= a;
              lo    <= '1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            state   <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem <= stepRem;
          quo <= {quo[WIDTH-2:0], stepQ};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          // Divide-by-zero is forced here rather than trusting what the iterations left behind.
          if (bZero) begin
            hi <= aOrig;
            lo <= '1;
          end else begin
            lo <= signQ ? negW(quo) : quo;
            hi <= signR ? negW(rem[WIDTH-1:0]) : rem[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_unit;

  localparam int W        = 32;
  localparam int FULL_LAT = W + 2;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ack;
  logic         flush;
  logic         stall_req;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           compared   = 0;
  int           mismatched = 0;
  logic [W-1:0] lastHi;
  logic [W-1:0] lastLo;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .a         (a),
    .b         (b),
    .ack       (ack),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit integer division truncates toward zero, remainder takes the dividend's sign.
  function automatic void refDiv(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    longint na;
    longint nb;
    if (bv == '0) begin
      q = '1;
      r = av;
      return;
    end
    na = s ? longint'($signed(av)) : longint'({32'b0, av});
    nb = s ? longint'($signed(bv)) : longint'({32'b0, bv});
    q  = W'(na / nb);
    r  = W'(na % nb);
  endfunction

  task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start      = 1'b1;
    signed_div = s;
    a          = av;
    b          = bv;
    ack        = 1'b0;
    flush      = 1'b0;
    #1;
    check("accept-cycle stall_req", stall_req, 1);
  endtask

  // Counts cycles from accept to done; scrambles operands after accept to prove they are not re-sampled.
  task automatic waitDone(input string tag, input int expLat, input int dropAt);
    int lat;
    bit stallGap;
    lat      = -1;
    stallGap = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 2) begin
        a = $urandom;
        b = $urandom;
      end
      if (c == dropAt) start = 1'b0;
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (stall_req !== 1'b1) stallGap = 1'b1;
    end
    check({tag, " latency"}, lat, expLat);
    check({tag, " stall gap"}, stallGap, 0);
    check({tag, " stall in done"}, stall_req, 0);
  endtask

  task automatic checkResult(input string tag, input logic s, input logic [W-1:0] av,
                             input logic [W-1:0] bv);
    logic [W-1:0] q;
    logic [W-1:0] r;
    refDiv(s, av, bv, q, r);
    check({tag, " hi"}, hi, r);
    check({tag, " lo"}, lo, q);
    lastHi = r;
    lastLo = q;
  endtask

  task automatic ackResult();
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic runOne(input string tag, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int expLat, input int dropAt);
    issue(s, av, bv);
    waitDone(tag, expLat, dropAt);
    checkResult(tag, s, av, bv);
    ackResult();
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    bit           doneSeen;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; ack = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset done", done, 0);
    check("reset stall_req", stall_req, 0);
    @(negedge clk);
    rst = 1'b0;

    runOne("divu 100/7", 1'b0, 32'd100, 32'd7, FULL_LAT, 0);
    runOne("div -7/2 start dropped", 1'b1, 32'hFFFF_FFF9, 32'd2, FULL_LAT, 5);
    runOne("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, FULL_LAT, 0);
    runOne("divu by zero", 1'b0, 32'h1234_5678, 32'd0, ZERO_LAT, 0);
    runOne("div by zero", 1'b1, 32'h8765_4321, 32'd0, ZERO_LAT, 0);

    // Result must hold while ack stays low, then a new divide follows straight after the ack.
    issue(1'b0, 32'd1000, 32'd33);
    waitDone("hold", FULL_LAT, 0);
    checkResult("hold", 1'b0, 32'd1000, 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold %0d done", i), done, 1);
      check($sformatf("hold %0d hi", i), hi, lastHi);
      check($sformatf("hold %0d lo", i), lo, lastLo);
      check($sformatf("hold %0d stall_req", i), stall_req, 0);
    end
    ack = 1'b1;
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    waitDone("after hold", FULL_LAT, 0);
    checkResult("after hold", 1'b1, 32'hFFFF_FF9C, 32'd7);
    ack = 1'b1;

    // Back-to-back DIVU: the second divide is accepted the cycle after the first is acked.
    issue(1'b0, 32'd50, 32'd5);
    waitDone("b2b first", FULL_LAT, 0);
    checkResult("b2b first", 1'b0, 32'd50, 32'd5);
    ack = 1'b1;
    issue(1'b0, 32'd9, 32'd4);
    waitDone("b2b second", FULL_LAT, 0);
    checkResult("b2b second", 1'b0, 32'd9, 32'd4);
    ackResult();

    // Flush in the tenth BUSY cycle.
    issue(1'b1, 32'hFFFF_0000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush-cycle stall_req", stall_req, 0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("post-flush stall_req", stall_req, 0);
    check("post-flush done", done, 0);
    check("post-flush hi", hi, lastHi);
    check("post-flush lo", lo, lastLo);
    doneSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0) doneSeen = 1'b1;
    end
    check("flushed divide never done", doneSeen, 0);

    // Reset mid-BUSY wins over a simultaneous flush.
    issue(1'b0, 32'd77, 32'd3);
    repeat (6) @(negedge clk);
    rst   = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("mid-busy reset hi", hi, 0);
    check("mid-busy reset lo", lo, 0);
    check("mid-busy reset done", done, 0);
    check("mid-busy reset stall_req", stall_req, 0);
    runOne("after reset", 1'b0, 32'd77, 32'd3, FULL_LAT, 0);

    for (int n = 0; n < 24; n++) begin
      rs = 1'(($urandom) & 1);
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        4:       rb = '1;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      runOne($sformatf("rand %0d", n), rs, ra, rb, (rb == '0) ? ZERO_LAT : FULL_LAT, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
